// File: rtl/lsu_pkg.sv
// Shared types and funct3 decoding for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = 3'd1;
            F3_H, F3_HU: f3_size = 3'd2;
            default:     f3_size = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte-enable mask and shifted store data over a two-word
// window, plus extraction and sign/zero extension of load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [63:0] rbuf,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output logic [31:0] rdata
);

    logic [2:0]  size;
    logic [7:0]  mask8;
    logic [31:0] sh;

    assign size  = f3_size(funct3);
    assign mask8 = (size == 3'd1) ? 8'h01 : (size == 3'd2) ? 8'h03 : 8'h0F;
    assign be8   = mask8 << offset;
    assign wd64  = {32'h0, wdata} << {offset, 3'b000};
    assign sh    = 32'(rbuf >> {offset, 3'b000});

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{sh[7]}}, sh[7:0]};
            F3_H:    rdata = {{16{sh[15]}}, sh[15:0]};
            F3_W:    rdata = sh;
            F3_BU:   rdata = {24'h0, sh[7:0]};
            F3_HU:   rdata = {16'h0, sh[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request, issues one or two word
// accesses to the data RAM, and returns a single-cycle response.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wData,
    output logic [3:0]  mem_Byte_Enable,
    input  logic [31:0] mem_rData
);

    lsu_state_e  state, state_nx;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic [31:0] buf0, buf1;
    logic [31:0] hold_rdata;
    logic        hold_err;

    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] ld_data;
    logic [31:0] rsp_data_now;
    logic        crossing;

    lsu_align u_align (
        .offset (lat_addr[1:0]),
        .funct3 (lat_f3),
        .wdata  (lat_wdata),
        .rbuf   ({buf1, buf0}),
        .be8    (be8),
        .wd64   (wd64),
        .rdata  (ld_data)
    );

    // Any lane set in the upper half of the window means the access spills
    // into the next word.
    assign crossing     = |be8[7:4];
    assign rsp_data_now = (lat_we || lat_err) ? '0 : ld_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_f3     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_err    <= 1'b0;
            buf0       <= '0;
            buf1       <= '0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    lat_we    <= req_we;
                    lat_f3    <= req_funct3;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                    lat_err   <= !f3_legal(req_we, req_funct3);
                end
                ACC0: buf0 <= mem_rData;
                ACC1: buf1 <= mem_rData;
                RESP: begin
                    hold_rdata <= rsp_data_now;
                    hold_err   <= lat_err;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx        = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wData       = '0;
        mem_Byte_Enable = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = f3_legal(req_we, req_funct3) ? ACC0 : RESP;
            end
            ACC0: begin
                mem_we          = lat_we;
                mem_addr        = {lat_addr[31:2], 2'b00};
                mem_wData       = wd64[31:0];
                mem_Byte_Enable = be8[3:0];
                state_nx        = crossing ? ACC1 : RESP;
            end
            ACC1: begin
                mem_we          = lat_we;
                mem_addr        = {lat_addr[31:2] + 30'd1, 2'b00};
                mem_wData       = wd64[63:32];
                mem_Byte_Enable = be8[7:4];
                state_nx        = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Live value during the response cycle, held copy afterwards.
    assign rsp_rdata = (state == RESP) ? rsp_data_now : hold_rdata;
    assign rsp_err   = (state == RESP) ? lat_err : hold_err;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the CPU execute stage and the word-organised data RAM. It accepts one load or store per handshake, decodes RV32I `funct3` into byte enables and lane-shifted write data, and sequences one or two word accesses. Two accesses are needed when a halfword or word access crosses a word boundary. For loads it assembles, extracts and sign/zero-extends the result. It returns a one-cycle response for every accepted request.

## Interface
Parameters:
- none. Data and address width are fixed at 32 bits.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; equals (state == IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: illegal `funct3`; qualified by `rsp_valid`.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 32: word-aligned RAM address (bits [1:0] = 00).
- `mem_wData` out 32: lane-positioned write data.
- `mem_Byte_Enable` out 4: per-byte write enable.
- `mem_rData` in 32: RAM read data, combinational from `mem_addr`.

## Operation
- **State machine** (`IDLE`, `ACC0`, `ACC1`, `RESP`):
  - `IDLE`: on `req_valid`, latch we/funct3/addr/wdata. Go to `RESP` with err if funct3 is illegal; otherwise go to `ACC0`.
  - `ACC0`: drive the first word. Go to `ACC1` if (offset + size) > 4, else `RESP`.
  - `ACC1`: drive the next word. Go to `RESP`.
  - `RESP`: assert `rsp_valid`. Go to `IDLE`.
- **Illegal funct3**: loads 011/110/111; stores with funct3[2]=1 or 011. No RAM access; `rsp_err`=1, `rsp_rdata`=0.
- **Size and lane mask**: size = 1/2/4 bytes. offset = addr[1:0]. be8 = ((1<<size)−1) << offset.
  - `ACC0` drives be8[3:0] at word addr & ~3.
  - `ACC1` drives be8[7:4] at (addr & ~3) + 4, modulo 2^32. So 0xFFFFFFFC + 4 wraps to 0x00000000.
- **Store data**: wd64 = zero-extended wdata << (8·offset). `ACC0` drives wd64[31:0]; `ACC1` drives wd64[63:32].
- **Write enable**: `mem_we` = store in an `ACC` state; 0 in all other states.
- **Load capture**: `ACC0` captures `mem_rData` into buf0; `ACC1` into buf1. For a single-word access buf1 is don't-care.
- **Load result**: ({buf1,buf0} >> 8·offset), truncated to size. LB/LH sign-extend; LBU/LHU/LW zero-extend.
- **Loads with enables**: `mem_Byte_Enable` is still driven as computed (the RAM ignores it on read); `mem_we`=0.
- **Idle outputs**: outside `ACC` states, `mem_addr`, `mem_wData` and `mem_Byte_Enable` are 0.

## Timing
- **Reset values**: state `IDLE`, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wData`=0, `mem_Byte_Enable`=0, buffers 0.
- **Requests during reset**: ignored.
- **Latency**: measured from the accept edge (edge where `req_valid` && `req_ready`) to `rsp_valid`.
  - Aligned or non-crossing access: `rsp_valid` is high in the 2nd cycle after accept.
  - Crossing access: 3rd cycle.
  - Illegal request: 1st cycle.
- **Throughput**: no back-to-back accept. `req_ready`=0 from `ACC0` through `RESP`; the next request is accepted in `IDLE` at the earliest one cycle after `rsp_valid`.
- **Response**: `rsp_valid` is a single-cycle pulse with no backpressure. `rsp_rdata`/`rsp_err` hold until the next response.
- **Store commit**: each write half commits at the rising edge that ends its `ACC` cycle.
- **Reset mid-operation**: all outputs drop to reset values immediately (async).
  - A crossing store interrupted in `ACC1` leaves the first half written and the second half not written.
  - No response is issued for the interrupted request.
- **Request inputs**: need only be stable at the accept edge; they are latched there.

## Structure
- **Package `lsu_pkg`**:
  - `lsu_state_e` enum (`IDLE`/`ACC0`/`ACC1`/`RESP`).
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - function returning size from funct3.
- **Sub-module `lsu_align`** (combinational): offset/size/wdata → be8 and wd64, plus the load extract/extend path. `lsu_ctrl` holds the FSM, request latches and read buffers.

## Test plan
- **SW aligned**: SW addr 0x8, wdata 0xDEADBEEF → one `ACC` cycle, `mem_addr` 0x8, `mem_Byte_Enable` 1111, `mem_wData` 0xDEADBEEF; `rsp_valid` 2 cycles after accept.
- **SB lane**: SB addr 0x5, wdata 0x000000A5 → `mem_addr` 0x4, `mem_Byte_Enable` 0010, `mem_wData` 0x0000A500; `rsp_err`=0.
- **LB / LBU extend**: RAM word@0x4 = 0x80FF7F01.
  - LB 0x6 → `rsp_rdata` 0xFFFFFFFF.
  - LBU 0x7 → 0x00000080.
  - LH 0x4 → 0x00007F01.
- **Crossing SW**: SW addr 0x6, wdata 0x11223344 → `ACC0` addr 0x4 be 1100 data 0x33440000; `ACC1` addr 0x8 be 0011 data 0x00001122; `rsp_valid` 3 cycles after accept.
  - Readback: LW 0x6 → 0x11223344.
- **Illegal and wrap**:
  - Load funct3 011 → `rsp_valid` with `rsp_err`=1, `rsp_rdata`=0 one cycle after accept; no `mem_we`.
  - LH 0xFFFFFFFF → `ACC1` `mem_addr` 0x00000000.
- **Reset mid-crossing store**: assert `reset` during `ACC1` → `mem_we` drops the same cycle, `req_ready`=1 after release, no `rsp_valid`, only the first-half bytes are modified.
